// File: rtl/rev_serial_adder.sv
// Bit-serial reversible adder: one reversible full-adder cell reused over WIDTH
// cycles. Forward adds a into b with the carry folded into z; reverse undoes it.
module rev_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             z_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             z_r, dir_r, carry;
  logic [CW-1:0]    cnt;
  logic             abit, bbit, res, c_next;

  // Forward carry-out and reverse borrow-out coincide, so z is restored on undo.
  always_comb begin
    abit   = a_sh[0];
    bbit   = b_sh[0];
    res    = abit ^ bbit ^ carry;
    c_next = (abit & bbit) | (abit & carry) | (bbit & carry);
    if (dir_r) begin
      c_next = (~bbit & abit) | (~(bbit ^ abit) & carry);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      z_out <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      z_r   <= 1'b0;
      dir_r <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            z_r   <= z_in;
            dir_r <= dir;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // LSB consumed each cycle; result bit enters at the MSB, a rotates back.
          a_sh  <= (a_sh >> 1) | (WIDTH'(abit) << (WIDTH - 1));
          b_sh  <= (b_sh >> 1) | (WIDTH'(res) << (WIDTH - 1));
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            z_r   <= z_r ^ c_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          a_out <= a_sh;
          b_out <= b_sh;
          z_out <= z_r;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
